move_scheduler: RTL and testbench
=================================

Name: move_scheduler

Overview:
- Time-multiplexes the single wall-map ROM between Pac-Man and the ghosts. On each game tick it walks every agent in fixed order.
- For each agent it computes the neighbouring tile from that agent's one-hot direction, checks the wall bit, and commits or rejects the move.
- Owns the authoritative position register of every agent. Sits between the controller/ghost-AI direction sources and the renderer/collision logic.

Parameters:
- N_AGENTS, 4, number of agents; agent 0 is Pac-Man.
- START_POS, {10'd1022,10'd993,10'd62,10'd33}, packed reset position per agent; agent i occupies bits [10i+9:10i].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse that starts a movement round
- dir  in  4*N_AGENTS  per-agent {up,down,left,right}; agent i occupies bits [4i+3:4i]
- rom_addr  out  5  row address to the wall ROM
- rom_data  in  32  row word from the ROM, registered, 1-cycle read latency; bit (31-col)=1 means wall
- pos  out  10*N_AGENTS  current tile address per agent (row*32+col)
- moved  out  N_AGENTS  bit i=1 if agent i moved in the last completed round
- busy  out  1  high while a round is in progress
- done  out  1  one-cycle pulse when a round completes
- overrun  out  1  sticky; set when tick arrives while busy, cleared only by reset

Behaviour:
- Reset values:
  - pos=START_POS
  - moved=0, busy=0, done=0, overrun=0
  - rom_addr=0
  - state=S_IDLE, agent index idx=0
- States: S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE.
- S_IDLE: when tick=1, set idx=0 and go to S_ISSUE; busy is high from the next cycle.
- S_ISSUE: sample dir[idx] and compute the target from cur=pos[idx], row=cur[9:5], col=cur[4:0]:
  - 4'b1000 (up): cur-32 if row!=0, else blocked.
  - 4'b0100 (down): cur+32 if row!=31, else blocked.
  - 4'b0010 (left): cur-1 if col!=0, else blocked; no row wrap-around.
  - 4'b0001 (right): cur+1 if col!=31, else blocked; no row wrap-around.
  - Any other pattern (none or multiple bits set) is treated as stay.
  - Register target_reg and a flag skip=(blocked or stay). Go to S_WAIT.
- S_WAIT: rom_addr=target_reg[9:5]; the ROM captures it at the end of this cycle. Go to S_CHECK.
  - rom_addr holds target_reg[9:5] from S_WAIT through S_CHECK.
- S_CHECK: wall = rom_data[31-target_reg[4:0]].
  - If !skip && !wall: pos[idx]<=target_reg and moved[idx]<=1.
  - Otherwise pos[idx] is unchanged and moved[idx]<=0.
  - If idx==N_AGENTS-1 go to S_DONE; else idx++ and go to S_ISSUE.
- S_DONE: done=1 for exactly this cycle, busy=0 in this cycle, return to S_IDLE.
- Latency: tick at cycle T gives done at T+1+3*N_AGENTS (T+13 for N=4). pos[i] updates at the end of agent i's S_CHECK.
- All address arithmetic is 10-bit unsigned; the edge checks guarantee no overflow or underflow.
- tick while busy or in S_DONE: ignored, and overrun<=1. The round in progress is unaffected.
- dir changes mid-round: only the value sampled in each agent's own S_ISSUE cycle matters.
- Agents are checked independently; agents may occupy the same tile (collision is resolved downstream).
- Reset asserted mid-round: next cycle all outputs take reset values; no partial commit survives.

Test Plan:
1. Reset, then check initial state:
   - pos = {1022,993,62,33}, busy=0.
   - tick with all dir=0 → done exactly 13 cycles after tick, pos unchanged, moved=0.
2. ROM row 1 = 0x8000_0001 (columns 0 and 31 walls), other rows 0. Agent0 at 33 (row 1, col 1):
   - dir0=right, tick → pos0=34, moved[0]=1.
   - Reset (agent0 back at 33), dir0=left, tick → target 32, wall → pos0=33, moved[0]=0, rom_addr=1 seen during agent0's S_WAIT.
3. Edge blocks: force an agent to col 31 with dir=right, and one to row 0 with dir=up, all ROM zero → no move, pos unchanged.
   - Confirm left from col 0 does not wrap to the previous row.
4. Illegal direction: dir0=4'b1010 → treated as stay; pos0 unchanged, moved[0]=0.
5. Overrun and sampling:
   - Pulse tick, pulse tick again 4 cycles later → overrun=1, only one done pulse.
   - Change dir3 after agent 3's S_ISSUE → the new value is not used.
6. Reset mid-round: assert reset during agent 2's S_WAIT → pos=START_POS, busy=0, done=0, overrun=0 on the next cycle.

Source files
------------

// File: rtl/move_scheduler_if.sv
// Bus between the movement scheduler and its environment: direction sources,
// wall ROM, and the position/status consumers.
interface move_scheduler_if #(
    parameter int N_AGENTS = 4
);
    // tick is a fire-and-forget pulse with no ready: it is accepted only while
    // the scheduler is idle; a tick at any other time is dropped and latches overrun.
    logic                    tick;
    logic [4*N_AGENTS-1:0]   dir;
    logic [4:0]              rom_addr;
    logic [31:0]             rom_data;
    logic [10*N_AGENTS-1:0]  pos;
    logic [N_AGENTS-1:0]     moved;
    logic                    busy;
    logic                    done;
    logic                    overrun;
    logic [2:0]              state_dbg;

    modport master (
        output tick, dir, rom_data,
        input  rom_addr, pos, moved, busy, done, overrun, state_dbg
    );

    modport slave (
        input  tick, dir, rom_data,
        output rom_addr, pos, moved, busy, done, overrun, state_dbg
    );
endinterface

// File: rtl/move_scheduler.sv
// Walks all agents once per tick, sharing the single wall ROM, and commits
// each agent's one-tile move unless it hits a wall or the map edge.
module move_scheduler #(
    parameter int                     N_AGENTS  = 4,
    parameter logic [10*N_AGENTS-1:0] START_POS = {10'd1022, 10'd993, 10'd62, 10'd33}
) (
    input  logic              clk,
    input  logic              reset,
    move_scheduler_if.slave   bus
);
    localparam int IDX_W = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_AGENTS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_idx;
    logic [10*N_AGENTS-1:0]  r_pos;
    logic [N_AGENTS-1:0]     r_moved;
    logic [9:0]              r_target;
    logic                    r_skip;
    logic [4:0]              r_rom_addr;
    logic                    r_overrun;

    logic [9:0]              w_cur;
    logic [3:0]              w_dir;
    logic [9:0]              w_target;
    logic                    w_skip;
    logic                    w_wall;

    // Candidate tile for the current agent; anything but a legal one-hot step is a stay.
    always_comb begin
        w_cur    = r_pos[r_idx*10 +: 10];
        w_dir    = bus.dir[r_idx*4 +: 4];
        w_target = w_cur;
        w_skip   = 1'b1;
        case (w_dir)
            4'b1000: if (w_cur[9:5] != 5'd0) begin
                w_target = w_cur - 10'd32;
                w_skip   = 1'b0;
            end
            4'b0100: if (w_cur[9:5] != 5'd31) begin
                w_target = w_cur + 10'd32;
                w_skip   = 1'b0;
            end
            4'b0010: if (w_cur[4:0] != 5'd0) begin
                w_target = w_cur - 10'd1;
                w_skip   = 1'b0;
            end
            4'b0001: if (w_cur[4:0] != 5'd31) begin
                w_target = w_cur + 10'd1;
                w_skip   = 1'b0;
            end
            default: ;
        endcase
    end

    // Column 0 is the MSB of the ROM row word.
    assign w_wall = bus.rom_data[5'd31 - r_target[4:0]];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.tick) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_CHECK;
            S_CHECK: w_next_state = (r_idx == LAST_IDX) ? S_DONE : S_ISSUE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_pos      <= START_POS;
            r_moved    <= '0;
            r_target   <= '0;
            r_skip     <= 1'b1;
            r_rom_addr <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (bus.tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (bus.tick) r_idx <= '0;
                // rom_addr is loaded here so it already shows the target row in S_WAIT
                S_ISSUE: begin
                    r_target   <= w_target;
                    r_skip     <= w_skip;
                    r_rom_addr <= w_target[9:5];
                end
                S_CHECK: begin
                    if (!r_skip && !w_wall) begin
                        r_pos[r_idx*10 +: 10] <= r_target;
                        r_moved[r_idx]        <= 1'b1;
                    end else begin
                        r_moved[r_idx]        <= 1'b0;
                    end
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.pos       = r_pos;
    assign bus.moved     = r_moved;
    assign bus.busy      = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign bus.done      = (r_state == S_DONE);
    assign bus.overrun   = r_overrun;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: a reference model predicts each
// round's positions and moved flags, which are queued and compared on done.
module tb_move_scheduler;
    localparam logic [39:0] START = {10'd1022, 10'd993, 10'd62, 10'd33};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    move_scheduler_if #(.N_AGENTS(4)) ifc ();

    move_scheduler #(.N_AGENTS(4), .START_POS(START)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // Wall ROM model with one-cycle registered read.
    logic [31:0] rom [32];
    always @(posedge clk) ifc.rom_data <= rom[ifc.rom_addr];

    int n_compared   = 0;
    int n_mismatched = 0;
    int done_cnt     = 0;
    logic [4:0]  seen_addr;
    logic [39:0] model_pos;
    logic [3:0]  model_moved;
    logic [43:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_round(input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            logic [9:0] cur;
            logic [9:0] tgt;
            logic       stay;
            int         bit_i;
            cur  = model_pos[10*i +: 10];
            tgt  = cur;
            stay = 1'b0;
            case (d[4*i +: 4])
                4'b1000: if (cur[9:5] == 5'd0)  stay = 1'b1; else tgt = cur - 10'd32;
                4'b0100: if (cur[9:5] == 5'd31) stay = 1'b1; else tgt = cur + 10'd32;
                4'b0010: if (cur[4:0] == 5'd0)  stay = 1'b1; else tgt = cur - 10'd1;
                4'b0001: if (cur[4:0] == 5'd31) stay = 1'b1; else tgt = cur + 10'd1;
                default: stay = 1'b1;
            endcase
            bit_i = 31 - int'(tgt[4:0]);
            if (!stay && rom[tgt[9:5]][bit_i] == 1'b0) begin
                model_pos[10*i +: 10] = tgt;
                model_moved[i]        = 1'b1;
            end else begin
                model_moved[i]        = 1'b0;
            end
        end
    endfunction

    // Scoreboard: every done pulse consumes one predicted round.
    always @(negedge clk) begin
        if (!reset && ifc.done) begin
            logic [43:0] e;
            done_cnt++;
            check("done_has_expectation", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("round_pos", ifc.pos, e[39:0]);
                check("round_moved", ifc.moved, e[43:40]);
                check("busy_low_in_done", ifc.busy, 0);
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        ifc.tick = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        model_pos   = START;
        model_moved = '0;
    endtask

    task automatic clear_rom();
        for (int r = 0; r < 32; r++) rom[r] = 32'h0;
    endtask

    // One movement round; optional re-tick at cycle retick_at and dir swap at alt_at.
    task automatic run_round(input logic [15:0] d, input int retick_at,
                             input int alt_at, input logic [15:0] alt_dir);
        int n;
        ifc.dir = d;
        model_round(d);
        exp_q.push_back({model_moved, model_pos});
        ifc.tick = 1'b1;
        @(negedge clk);
        ifc.tick = 1'b0;
        n = 1;
        check("busy_after_tick", ifc.busy, 1);
        while (!ifc.done && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) seen_addr = ifc.rom_addr;
            ifc.tick = (n == retick_at);
            if (n == alt_at) ifc.dir = alt_dir;
        end
        ifc.tick = 1'b0;
        check("done_latency", n, 13);
        @(negedge clk);
        check("busy_after_done", ifc.busy, 0);
        check("done_one_cycle", ifc.done, 0);
    endtask

    initial begin
        int dc0;
        ifc.tick = 1'b0;
        ifc.dir  = '0;
        clear_rom();

        // 1: reset state and an all-stay round
        do_reset();
        check("rst_pos", ifc.pos, START);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_overrun", ifc.overrun, 0);
        check("rst_moved", ifc.moved, 0);
        check("rst_rom_addr", ifc.rom_addr, 0);
        check("rst_state", ifc.state_dbg, 0);
        run_round(16'h0000, 0, 0, 16'h0);
        check("t1_pos_unchanged", ifc.pos, START);

        // 2: wall row 1 has walls in columns 0 and 31
        rom[1] = 32'h8000_0001;
        run_round(16'h0001, 0, 0, 16'h0);
        check("t2_right_pos0", ifc.pos[9:0], 34);
        check("t2_right_moved0", ifc.moved[0], 1);
        do_reset();
        run_round(16'h0002, 0, 0, 16'h0);
        check("t2_left_wall_pos0", ifc.pos[9:0], 33);
        check("t2_left_wall_moved0", ifc.moved[0], 0);
        check("t2_rom_addr_wait", seen_addr, 1);

        // 3: map edges, ROM empty
        clear_rom();
        do_reset();
        run_round({4'b0100, 4'b0010, 4'b0001, 4'b1000}, 0, 0, 16'h0);
        check("t3a_pos0_row0", ifc.pos[9:0], 1);
        check("t3a_pos1_col31", ifc.pos[19:10], 63);
        check("t3a_pos2_col0", ifc.pos[29:20], 992);
        check("t3a_pos3_bottom", ifc.pos[39:30], 1022);
        run_round({4'b0100, 4'b0010, 4'b0001, 4'b1000}, 0, 0, 16'h0);
        check("t3b_up_blocked", ifc.pos[9:0], 1);
        check("t3b_right_blocked", ifc.pos[19:10], 63);
        check("t3b_left_nowrap", ifc.pos[29:20], 992);
        check("t3b_moved", ifc.moved, 0);
        run_round({4'b0000, 4'b0000, 4'b0000, 4'b0010}, 0, 0, 16'h0);
        check("t3c_pos0_col0", ifc.pos[9:0], 0);
        run_round({4'b0000, 4'b0000, 4'b0000, 4'b0010}, 0, 0, 16'h0);
        check("t3d_left_row0_nowrap", ifc.pos[9:0], 0);

        // 4: illegal direction patterns are stays
        do_reset();
        run_round({4'b0110, 4'b0011, 4'b1111, 4'b1010}, 0, 0, 16'h0);
        check("t4_illegal_pos", ifc.pos, START);
        check("t4_illegal_moved", ifc.moved, 0);

        // 5: second tick while busy, and dir3 changed after its sample point
        do_reset();
        check("t5_overrun_pre", ifc.overrun, 0);
        dc0 = done_cnt;
        run_round(16'h0000, 4, 11, 16'h8000);
        repeat (3) @(negedge clk);
        check("t5_overrun", ifc.overrun, 1);
        check("t5_one_done", done_cnt - dc0, 1);
        check("t5_dir3_late_ignored", ifc.pos[39:30], 1022);
        ifc.dir = 16'h0;

        // 6: reset during agent 2's wait cycle
        do_reset();
        ifc.dir  = {4'b0000, 4'b0000, 4'b0100, 4'b0001};
        ifc.tick = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            ifc.tick = (n == 3);
        end
        ifc.tick = 1'b0;
        check("t6_pre_pos0", ifc.pos[9:0], 34);
        check("t6_pre_overrun", ifc.overrun, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_pos", ifc.pos, START);
        check("t6_busy", ifc.busy, 0);
        check("t6_done", ifc.done, 0);
        check("t6_overrun", ifc.overrun, 0);
        check("t6_moved", ifc.moved, 0);
        check("t6_state", ifc.state_dbg, 0);
        reset       = 1'b0;
        model_pos   = START;
        model_moved = '0;
        ifc.dir     = 16'h0;
        @(negedge clk);
        run_round(16'h0000, 0, 0, 16'h0);

        // Random walls and directions
        do_reset();
        for (int r = 0; r < 8; r++) begin
            logic [15:0] d;
            for (int row = 0; row < 32; row++) rom[row] = $urandom() & $urandom();
            for (int a = 0; a < 4; a++) begin
                case ($urandom_range(0, 5))
                    0: d[4*a +: 4] = 4'b1000;
                    1: d[4*a +: 4] = 4'b0100;
                    2: d[4*a +: 4] = 4'b0010;
                    3: d[4*a +: 4] = 4'b0001;
                    4: d[4*a +: 4] = 4'b0000;
                    default: d[4*a +: 4] = 4'($urandom_range(0, 15));
                endcase
            end
            run_round(d, 0, 0, 16'h0);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
